// File: rtl/mdu_timed_core.sv
// mdu_timed_core: multi-cycle multiply/divide unit with private HI/LO registers.
// The result is computed from the operands sampled at the issue edge and held
// in pending registers. It is committed to HI/LO after a fixed per-operation
// latency, and the commit is marked by a one-cycle o_done pulse. A RUN can be
// cancelled by i_flush. MTHI/MTLO write HI/LO in a single cycle from IDLE.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   i_start  issue i_op this cycle
//   i_op     0 NOOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, else NOOP
//   i_a      rs operand (dividend, MTHI/MTLO source)
//   i_b      rt operand (divisor)
//   i_flush  cancel the issuing or in-flight operation
//   o_busy   combinational stall request
//   o_done   one-cycle pulse, HI/LO just committed
//   o_hi     HI register
//   o_lo     LO register
module mdu_timed_core #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned PROD_W     = 2 * WIDTH;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_pend_hi;
    logic [WIDTH-1:0]  r_pend_lo;
    logic              r_done;

    // Operation decode
    logic w_is_mul;
    logic w_is_div;
    logic w_is_md;
    logic w_signed;
    logic w_issue;

    assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_is_div = (i_op == OP_DIV)  || (i_op == OP_DIVU);
    assign w_is_md  = w_is_mul || w_is_div;
    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_issue  = i_start && !i_flush;

    // Multiply: sign- or zero-extend to full product width, keep the low 2*WIDTH bits
    logic [PROD_W-1:0] w_mul_a;
    logic [PROD_W-1:0] w_mul_b;
    logic [PROD_W-1:0] w_prod;

    assign w_mul_a = {{WIDTH{w_signed & i_a[WIDTH-1]}}, i_a};
    assign w_mul_b = {{WIDTH{w_signed & i_b[WIDTH-1]}}, i_b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. MIN / -1 falls out as quotient MIN, remainder 0.
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_uquot;
    logic [WIDTH-1:0] w_urem;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];
    assign w_b_zero = (i_b == '0);
    assign w_abs_a  = w_a_neg ? (-i_a) : i_a;
    // Divisor forced to 1 on zero so the datapath never sees x/0; result is discarded
    assign w_abs_b  = w_b_zero ? WIDTH'(1) : (w_b_neg ? (-i_b) : i_b);
    assign w_uquot  = w_abs_a / w_abs_b;
    assign w_urem   = w_abs_a % w_abs_b;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (-w_uquot) : w_uquot;
    assign w_rem    = w_a_neg ? (-w_urem) : w_urem;

    // Pending result select; divide by zero re-commits the current HI/LO
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_comb begin
        w_res_hi = w_prod[PROD_W-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (w_is_div) begin
            if (w_b_zero) begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    // Control FSM, counter, HI/LO and pending registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        if (w_is_md) begin
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_cnt     <= w_is_mul ? MULT_LOAD : DIV_LOAD;
                            r_state   <= ST_RUN;
                        end else if (i_op == OP_MTHI) begin
                            r_hi <= i_a;
                        end else if (i_op == OP_MTLO) begin
                            r_lo <= i_a;
                        end
                    end
                end
                ST_RUN: begin
                    // New starts are ignored here; only flush or the countdown matter
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_ONE) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stall covers the issue cycle as well as the whole RUN
    assign o_busy = (r_state == ST_RUN) || (w_issue && w_is_md);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_timed_core.sv
// Directed bench for mdu_timed_core: default instance (32-bit, 5/10 cycles)
// and a re-parametrised instance (16-bit, 1/33 cycles).
module tb_mdu_timed_core;

    logic clk;
    logic reset;

    logic        s_start0, s_flush0;
    logic [3:0]  s_op0;
    logic [31:0] s_a0, s_b0;
    logic        busy0, done0;
    logic [31:0] hi0, lo0;

    logic        s_start1, s_flush1;
    logic [3:0]  s_op1;
    logic [15:0] s_a1, s_b1;
    logic        busy1, done1;
    logic [15:0] hi1, lo1;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_timed_core u_dut0 (
        .clk(clk), .reset(reset), .i_start(s_start0), .i_op(s_op0),
        .i_a(s_a0), .i_b(s_b0), .i_flush(s_flush0),
        .o_busy(busy0), .o_done(done0), .o_hi(hi0), .o_lo(lo0)
    );

    mdu_timed_core #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(33)) u_dut1 (
        .clk(clk), .reset(reset), .i_start(s_start1), .i_op(s_op1),
        .i_a(s_a1), .i_b(s_b1), .i_flush(s_flush1),
        .o_busy(busy1), .o_done(done1), .o_hi(hi1), .o_lo(lo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue on dut0, check busy/done/HI/LO every cycle up to and after the commit
    task automatic run0(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        s_start0 = 1'b1; s_op0 = op; s_a0 = a; s_b0 = b;
        #1;
        check_eq({tag, "_busy_issue"}, 64'(busy0), 64'(1));
        tick();
        s_start0 = 1'b0; s_a0 = 32'hDEAD_BEEF; s_b0 = 32'h0000_0000;
        for (int k = 1; k <= lat; k++) begin
            check_eq({tag, "_busy_run"}, 64'(busy0), 64'(1));
            check_eq({tag, "_done_run"}, 64'(done0), 64'(0));
            check_eq({tag, "_hi_hold"}, 64'(hi0), 64'(old_hi));
            check_eq({tag, "_lo_hold"}, 64'(lo0), 64'(old_lo));
            tick();
        end
        check_eq({tag, "_busy_commit"}, 64'(busy0), 64'(0));
        check_eq({tag, "_done_commit"}, 64'(done0), 64'(1));
        check_eq({tag, "_hi"}, 64'(hi0), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(lo0), 64'(exp_lo));
        tick();
        check_eq({tag, "_done_after"}, 64'(done0), 64'(0));
        check_eq({tag, "_hi_after"}, 64'(hi0), 64'(exp_hi));
    endtask

    task automatic run1(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] old_hi, input logic [15:0] old_lo,
                        input logic [15:0] exp_hi, input logic [15:0] exp_lo);
        s_start1 = 1'b1; s_op1 = op; s_a1 = a; s_b1 = b;
        #1;
        check_eq({tag, "_busy_issue"}, 64'(busy1), 64'(1));
        tick();
        s_start1 = 1'b0; s_a1 = 16'hBEEF; s_b1 = 16'h0000;
        for (int k = 1; k <= lat; k++) begin
            check_eq({tag, "_busy_run"}, 64'(busy1), 64'(1));
            check_eq({tag, "_done_run"}, 64'(done1), 64'(0));
            check_eq({tag, "_hi_hold"}, 64'(hi1), 64'(old_hi));
            check_eq({tag, "_lo_hold"}, 64'(lo1), 64'(old_lo));
            tick();
        end
        check_eq({tag, "_busy_commit"}, 64'(busy1), 64'(0));
        check_eq({tag, "_done_commit"}, 64'(done1), 64'(1));
        check_eq({tag, "_hi"}, 64'(hi1), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(lo1), 64'(exp_lo));
        tick();
        check_eq({tag, "_done_after"}, 64'(done1), 64'(0));
    endtask

    initial begin
        reset = 1'b0;
        s_start0 = 1'b0; s_flush0 = 1'b0; s_op0 = 4'd0; s_a0 = '0; s_b0 = '0;
        s_start1 = 1'b0; s_flush1 = 1'b0; s_op1 = 4'd0; s_a1 = '0; s_b1 = '0;
        #3;
        check_eq("rst_hi0", 64'(hi0), 64'(0));
        check_eq("rst_lo0", 64'(lo0), 64'(0));
        check_eq("rst_busy0", 64'(busy0), 64'(0));
        check_eq("rst_done0", 64'(done0), 64'(0));
        check_eq("rst_busy1", 64'(busy1), 64'(0));
        check_eq("rst_hi1", 64'(hi1), 64'(0));
        #14;
        reset = 1'b1;
        tick();

        // Arithmetic on the default instance
        run0("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run0("divu", 4'd4, 32'd100, 32'd7, 10, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd2, 32'd14);
        run0("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run0("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             32'h0, 32'h8000_0000);
        run0("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0, 32'h8000_0000,
             32'hFFFF_FFFE, 32'h0000_0001);

        // MTHI / MTLO: single cycle, no busy, no done
        s_start0 = 1'b1; s_op0 = 4'd5; s_a0 = 32'h1234;
        #1;
        check_eq("mthi_busy", 64'(busy0), 64'(0));
        tick();
        s_start0 = 1'b1; s_op0 = 4'd6; s_a0 = 32'h5678;
        check_eq("mthi_hi", 64'(hi0), 64'(32'h1234));
        check_eq("mthi_lo_keep", 64'(lo0), 64'(32'h1));
        check_eq("mthi_done", 64'(done0), 64'(0));
        tick();
        s_start0 = 1'b0;
        check_eq("mtlo_lo", 64'(lo0), 64'(32'h5678));
        check_eq("mtlo_hi_keep", 64'(hi0), 64'(32'h1234));
        check_eq("mtlo_done", 64'(done0), 64'(0));

        // Divide by zero keeps HI/LO but still takes the full latency
        run0("div0", 4'd3, 32'd55, 32'd0, 10, 32'h1234, 32'h5678, 32'h1234, 32'h5678);
        run0("divu0", 4'd4, 32'hFFFF_0000, 32'd0, 10, 32'h1234, 32'h5678, 32'h1234, 32'h5678);

        // Flush sampled at E0+2 cancels the MULT
        s_start0 = 1'b1; s_op0 = 4'd1; s_a0 = 32'd2; s_b0 = 32'd3;
        tick();
        s_start0 = 1'b0;
        tick();
        s_flush0 = 1'b1;
        #1;
        check_eq("flush_busy_during", 64'(busy0), 64'(1));
        tick();
        s_flush0 = 1'b0;
        check_eq("flush_busy_after", 64'(busy0), 64'(0));
        for (int k = 0; k < 6; k++) begin
            check_eq("flush_no_done", 64'(done0), 64'(0));
            tick();
        end
        check_eq("flush_hi_keep", 64'(hi0), 64'(32'h1234));
        check_eq("flush_lo_keep", 64'(lo0), 64'(32'h5678));

        // Start together with flush is suppressed, including MTHI
        s_start0 = 1'b1; s_op0 = 4'd1; s_flush0 = 1'b1; s_a0 = 32'd9; s_b0 = 32'd9;
        #1;
        check_eq("sflush_busy_issue", 64'(busy0), 64'(0));
        tick();
        s_op0 = 4'd5;
        check_eq("sflush_busy_next", 64'(busy0), 64'(0));
        tick();
        s_start0 = 1'b0; s_flush0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_eq("sflush_no_done", 64'(done0), 64'(0));
            tick();
        end
        check_eq("sflush_hi_keep", 64'(hi0), 64'(32'h1234));
        check_eq("sflush_lo_keep", 64'(lo0), 64'(32'h5678));

        // Re-parametrised instance: 16-bit, 1-cycle multiply, 33-cycle divide
        run1("w16_mult", 4'd1, 16'hFED4, 16'd200, 1, 16'h0, 16'h0, 16'hFFFF, 16'h15A0);
        run1("w16_multu", 4'd2, 16'hFFFF, 16'h0002, 1, 16'hFFFF, 16'h15A0, 16'h0001, 16'hFFFE);
        run1("w16_divu", 4'd4, 16'd1000, 16'd7, 33, 16'h0001, 16'hFFFE, 16'd6, 16'd142);
        run1("w16_div", 4'd3, 16'hFC18, 16'd7, 33, 16'd6, 16'd142, 16'hFFFA, 16'hFF72);

        // DIV issued while a MULT runs is ignored
        s_start0 = 1'b1; s_op0 = 4'd1; s_a0 = 32'd6; s_b0 = 32'd7;
        tick();
        s_start0 = 1'b0;
        tick();
        s_start0 = 1'b1; s_op0 = 4'd3; s_a0 = 32'd100; s_b0 = 32'd3;
        #1;
        check_eq("ign_busy", 64'(busy0), 64'(1));
        tick();
        s_start0 = 1'b0;
        tick();
        tick();
        check_eq("ign_done_early", 64'(done0), 64'(0));
        check_eq("ign_lo_hold", 64'(lo0), 64'(32'h5678));
        tick();
        check_eq("ign_done", 64'(done0), 64'(1));
        check_eq("ign_busy_commit", 64'(busy0), 64'(0));
        check_eq("ign_hi", 64'(hi0), 64'(32'h0));
        check_eq("ign_lo", 64'(lo0), 64'(32'd42));
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("ign_no_div_done", 64'(done0), 64'(0));
        end
        check_eq("ign_lo_final", 64'(lo0), 64'(32'd42));

        // Reset asserted at E0+3 aborts the run immediately
        s_start0 = 1'b1; s_op0 = 4'd1; s_a0 = 32'd5; s_b0 = 32'd5;
        tick();
        s_start0 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rrun_hi", 64'(hi0), 64'(0));
        check_eq("rrun_lo", 64'(lo0), 64'(0));
        check_eq("rrun_busy", 64'(busy0), 64'(0));
        check_eq("rrun_done", 64'(done0), 64'(0));
        #2;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rrun_no_done", 64'(done0), 64'(0));
            check_eq("rrun_lo_zero", 64'(lo0), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_timed_core.md
Name: mdu_timed_core

Overview:
Parametrised multi-cycle multiply/divide unit with its own HI/LO registers. It computes the actual results and commits them after a per-operation latency. It adds three things to the plain delay counter: a one-cycle completion pulse, flush/cancel of an in-flight operation, and MTHI/MTLO writes. It sits in the EX stage beside the ALU, and its busy output drives the pipeline stall logic for MFHI/MFLO and further MDU instructions.

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_CYCLES, 5, clock edges from start sample to HI/LO commit for MULT/MULTU; must be >= 1.
DIV_CYCLES, 10, same for DIV/DIVU; must be >= 1.
Counter width is a localparam: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
i_start  in  1  issue the operation on i_op this cycle.
i_op  in  4  0=NOOP, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, others=NOOP. These values are normative for this block.
i_a  in  WIDTH  rs operand (dividend; MTHI/MTLO source).
i_b  in  WIDTH  rt operand (divisor).
i_flush  in  1  cancel the current or in-flight op (exception/interrupt).
o_busy  out  1  stall request.
o_done  out  1  one-cycle pulse, HI/LO just committed.
o_hi  out  WIDTH  HI register.
o_lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, counter=0, HI=LO=0, pending result=0, o_done=0. Outputs reflect this immediately.
- States: IDLE and RUN.
- IDLE, i_start=1, op is MULT/MULTU/DIV/DIVU, i_flush=0, at edge E0:
  - Compute the result from i_a/i_b and latch it into the pending HI/LO registers.
  - Load counter = MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN, each edge:
  - i_flush=1: go to IDLE, counter=0, HI/LO unchanged, no o_done.
  - Else if counter==1: HI/LO <= pending, go to IDLE, counter=0, o_done<=1.
  - Else: counter decrements.
- Commit timing: the commit happens at edge E0+LAT. o_done is high for exactly the cycle after that edge; new HI/LO are visible in the same cycle.
- o_busy (combinational) = (state==RUN) | (i_start & ~i_flush & op in {MULT,MULTU,DIV,DIVU}). It is high from the issue cycle through the cycle before the commit edge, and low during the o_done cycle.
- MTHI/MTLO in IDLE with i_start=1 and i_flush=0: HI (or LO) <= i_a at the next edge. Single cycle, no busy, no o_done.
- i_start while RUN: ignored. The pipeline must not issue it; o_busy stays high and counter and pending are unaffected.
- i_flush with i_start in the same cycle: the start is suppressed and the state is unchanged.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH; HI=upper, LO=lower.
  - MULTU: unsigned, same split.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV of most-negative / -1: LO = most-negative, HI = 0.
  - DIVU: unsigned.
  - Divide by zero (DIV or DIVU): full DIV_CYCLES latency and o_done still pulse; committed HI/LO equal their pre-start values.
- Operands are captured at E0. Later changes on i_a/i_b have no effect on the result.
- Reset asserted mid-RUN: aborts immediately to reset values, with no commit and no o_done.

Test Plan:
- MULT i_a=-3 (0xFFFFFFFD), i_b=7 at E0 -> o_busy high in the issue cycle through E0+4; HI=0xFFFFFFFF, LO=0xFFFFFFEB after E0+5; o_done high for one cycle only; HI/LO unchanged before E0+5.
- DIVU i_a=100, i_b=7 -> LO=14, HI=2 at E0+10. DIV i_a=-7, i_b=2 -> LO=-3, HI=-1. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Divide by zero after MTHI 0x1234 and MTLO 0x5678 -> 10 busy edges, o_done pulses, HI=0x1234, LO=0x5678.
- MULT issued, i_flush=1 at E0+2 -> o_busy low from the next cycle, HI/LO keep old values, o_done never pulses. A second start with flush in the same cycle -> no busy, state unchanged.
- i_start DIV during RUN of a MULT -> ignored; the MULT result commits at E0+5. Reset pulled low at E0+3 -> HI=LO=0, o_busy=0 immediately.
- Re-parametrise MULT_CYCLES=1, DIV_CYCLES=33, WIDTH=16 -> commits at E0+1 and E0+33; 16x16 product split correct; counter does not overflow.
